lvds_rx_word_align: RTL and testbench

//  Word-alignment controller downstream of the 7:1 LVDS deserializer.
//  - Watches the deserialized clock-lane word clk_phase.
//  - Pulses slip (deserializer CALIB) until clk_phase equals the LVDS clock pattern.
//  - Registers the four 7-bit data lanes; qualifies them with rx_valid once aligned.

---
 rtl/lvds_rx_pkg.sv | 20 ++
 rtl/lvds_rx_sync2.sv | 21 ++
 rtl/lvds_rx_word_align.sv | 138 +++++++++++++
 tb/tb_lvds_rx_word_align.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_rx_pkg.sv
// rtl/lvds_rx_pkg.sv - shared types and constants for the LVDS receive word aligner
package lvds_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SLIP,
    WAIT,
    ALIGNED
  } align_state_t;

  localparam logic [6:0] DEFAULT_CLK_PATTERN = 7'b1100011;
  localparam int         LANE_COUNT          = 4;
  localparam int         LANE_WIDTH          = 7;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/lvds_rx_sync2.sv
// rtl/lvds_rx_sync2.sv - two-flop synchronizer for a single asynchronous level
module lvds_rx_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lvds_rx_word_align.sv
// rtl/lvds_rx_word_align.sv - slips the 7:1 deserializer until the clock lane matches
// the LVDS clock pattern; optional in-lock monitor enabled by LVDS_ALIGN_MONITOR_EN.
module lvds_rx_word_align
  import lvds_rx_pkg::*;
#(
  parameter logic [6:0] CLK_PATTERN = DEFAULT_CLK_PATTERN,
  parameter int         LOCK_WAIT   = 1024,
  parameter int         CHECK_LEN   = 16,
  parameter int         SLIP_WAIT   = 8,
  parameter int         MAX_SLIP    = 7
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        pll_lock,
  input  logic [6:0]  clk_phase,
  input  logic [6:0]  q0,
  input  logic [6:0]  q1,
  input  logic [6:0]  q2,
  input  logic [6:0]  q3,
  output logic        slip,
  output logic        aligned,
  output logic        align_err,
  output logic [2:0]  slip_cnt,
  output logic [27:0] rx_data,
  output logic        rx_valid
);

  localparam int LOCK_W  = $clog2(LOCK_WAIT + 1);
  localparam int CHECK_W = $clog2(CHECK_LEN + 1);
  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);

  align_state_t       state, next_state;
  logic               lock_s;
  logic               phase_ok;
  logic               give_up;
  logic [LOCK_W-1:0]  lock_cnt;
  logic [CHECK_W-1:0] match_cnt;
  logic [WAIT_W-1:0]  wait_cnt;

  lvds_rx_sync2 u_lock_sync (
    .clk   (sclk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign phase_ok = (clk_phase == CLK_PATTERN);

`ifdef LVDS_ALIGN_MONITOR_EN
  logic [2:0] err_cnt;
  logic       monitor_trip;
  assign monitor_trip = !phase_ok && (err_cnt == 3'd3);
`endif

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Lock loss overrides every other transition.
  always_comb begin
    next_state = state;
    give_up    = 1'b0;
    if (!lock_s) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (lock_cnt == LOCK_W'(LOCK_WAIT - 1)) next_state = CHECK;
        CHECK: begin
          if (phase_ok) begin
            if (match_cnt == CHECK_W'(CHECK_LEN - 1)) next_state = ALIGNED;
          end else if (slip_cnt == 3'(MAX_SLIP)) begin
            give_up    = 1'b1;
            next_state = WAIT;
          end else begin
            next_state = SLIP;
          end
        end
        SLIP:    next_state = WAIT;
        WAIT:    if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) next_state = CHECK;
        ALIGNED: begin
`ifdef LVDS_ALIGN_MONITOR_EN
          if (monitor_trip) next_state = CHECK;
`endif
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Each counter only runs while its state persists, so none can wrap.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt  <= '0;
      match_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      lock_cnt  <= (state == IDLE  && next_state == IDLE && lock_s) ? lock_cnt + LOCK_W'(1) : '0;
      match_cnt <= (state == CHECK && next_state == CHECK) ? match_cnt + CHECK_W'(1) : '0;
      wait_cnt  <= (state == WAIT  && next_state == WAIT)  ? wait_cnt + WAIT_W'(1)   : '0;
    end
  end

`ifdef LVDS_ALIGN_MONITOR_EN
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n)                                        err_cnt <= 3'd0;
    else if (state == ALIGNED && next_state == ALIGNED) err_cnt <= phase_ok ? 3'd0 : err_cnt + 3'd1;
    else                                               err_cnt <= 3'd0;
  end
`endif

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      slip      <= 1'b0;
      aligned   <= 1'b0;
      align_err <= 1'b0;
      slip_cnt  <= 3'd0;
      rx_data   <= 28'd0;
    end else begin
      slip    <= (next_state == SLIP);
      aligned <= (state == ALIGNED) && (next_state == ALIGNED);
      rx_data <= {q3, q2, q1, q0};
      if (give_up) align_err <= 1'b1;
      if (!lock_s || give_up) begin
        slip_cnt <= 3'd0;
      end else if (state == SLIP) begin
        slip_cnt <= sat_inc3(slip_cnt);
`ifdef LVDS_ALIGN_MONITOR_EN
      end else if (state == ALIGNED && next_state == CHECK) begin
        slip_cnt <= 3'd0;
`endif
      end
    end
  end

  assign rx_valid = aligned;

endmodule

// File: tb/tb_lvds_rx_word_align.sv
// tb/tb_lvds_rx_word_align.sv - directed bench with a cycle model of the aligner
module tb_lvds_rx_word_align;

  localparam int         LW  = 16;
  localparam int         CL  = 16;
  localparam int         SW  = 8;
  localparam int         MS  = 7;
  localparam logic [6:0] PAT = 7'b1100011;

  localparam int M_IDLE = 0, M_CHECK = 1, M_SLIP = 2, M_WAIT = 3, M_ALIGNED = 4;

  logic        sclk = 1'b0;
  logic        rst_n, pll_lock;
  logic [6:0]  clk_phase, q0, q1, q2, q3;
  logic        slip, aligned, align_err, rx_valid;
  logic [2:0]  slip_cnt;
  logic [27:0] rx_data;

  lvds_rx_word_align #(
    .CLK_PATTERN (PAT),
    .LOCK_WAIT   (LW),
    .CHECK_LEN   (CL),
    .SLIP_WAIT   (SW),
    .MAX_SLIP    (MS)
  ) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .clk_phase (clk_phase),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .slip      (slip),
    .aligned   (aligned),
    .align_err (align_err),
    .slip_cnt  (slip_cnt),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid)
  );

  always #5 sclk = ~sclk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Deserializer stand-in: each slip pulse rotates the clock-lane word by one bit.
  int   rot         = 0;
  bit   never_match = 1'b0;
  int   bad_left    = 0;
  int   slip_times[$];

  function automatic logic [6:0] rotl(input logic [6:0] p, input int k);
    logic [6:0] r = p;
    for (int i = 0; i < k; i++) r = {r[5:0], r[6]};
    return r;
  endfunction

  always @(posedge sclk) begin
    cyc++;
    #2;
    if (slip === 1'b1) begin
      rot = (rot + 6) % 7;
      slip_times.push_back(cyc);
    end
    if (never_match || bad_left > 0) clk_phase = 7'h00;
    else                             clk_phase = rotl(PAT, rot);
    if (bad_left > 0) bad_left--;
    q0 = 7'(cyc * 3);
    q1 = 7'(cyc * 5 + 1);
    q2 = 7'(~cyc);
    q3 = 7'(cyc * 11 + 7);
  end

  // Behavioural model: lock history, run lengths and a mode per the alignment rules.
  bit          m_s1, m_s2;
  int          m_mode, m_lock_run, m_good_run, m_settle, m_bad_run;
  bit          m_slip, m_aligned, m_err;
  int          m_slips;
  logic [27:0] m_data;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0;
    m_mode = M_IDLE; m_lock_run = 0; m_good_run = 0; m_settle = 0; m_bad_run = 0;
    m_slip = 0; m_aligned = 0; m_err = 0; m_slips = 0; m_data = '0;
  endtask

  task automatic model_step();
    bit lock_seen = m_s2;
    bit good      = (clk_phase == PAT);
    int prev      = m_mode;
    m_s2   = m_s1;
    m_s1   = pll_lock;
    m_data = {q3, q2, q1, q0};
    if (!lock_seen) begin
      m_mode = M_IDLE; m_lock_run = 0; m_slips = 0;
    end else if (prev == M_IDLE) begin
      m_lock_run++;
      if (m_lock_run == LW) begin m_mode = M_CHECK; m_good_run = 0; m_lock_run = 0; end
    end else if (prev == M_CHECK) begin
      if (good) begin
        m_good_run++;
        if (m_good_run == CL) begin m_mode = M_ALIGNED; m_bad_run = 0; end
      end else if (m_slips == MS) begin
        m_err = 1; m_slips = 0; m_mode = M_WAIT; m_settle = 0;
      end else begin
        m_mode = M_SLIP;
      end
    end else if (prev == M_SLIP) begin
      if (m_slips < 7) m_slips++;
      m_mode = M_WAIT; m_settle = 0;
    end else if (prev == M_WAIT) begin
      m_settle++;
      if (m_settle == SW) begin m_mode = M_CHECK; m_good_run = 0; end
    end else begin
`ifdef LVDS_ALIGN_MONITOR_EN
      m_bad_run = good ? 0 : m_bad_run + 1;
      if (m_bad_run == 4) begin m_mode = M_CHECK; m_good_run = 0; m_slips = 0; end
`endif
    end
    m_slip    = (m_mode == M_SLIP);
    m_aligned = (prev == M_ALIGNED) && (m_mode == M_ALIGNED);
  endtask

  always @(negedge sclk) begin
    if (!rst_n) model_reset();
    check("slip",      32'(slip),      32'(m_slip));
    check("aligned",   32'(aligned),   32'(m_aligned));
    check("rx_valid",  32'(rx_valid),  32'(m_aligned));
    check("align_err", 32'(align_err), 32'(m_err));
    check("slip_cnt",  32'(slip_cnt),  32'(m_slips));
    check("rx_data",   32'(rx_data),   32'(m_data));
    if (rst_n) model_step();
  end

  // Counts rising clock edges until aligned is seen, bounded by max_cyc.
  task automatic wait_aligned(input int max_cyc, output int n);
    n = 0;
    while (n < max_cyc) begin
      @(posedge sclk); n++;
      #3;
      if (aligned === 1'b1) return;
    end
    n = -1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 0; pll_lock = 0;
    clk_phase = 7'h00; q0 = 7'h00; q1 = 7'h00; q2 = 7'h00; q3 = 7'h00;
    cycles(3);
    #2;
    check("reset_aligned",  32'(aligned),  32'd0);
    check("reset_slip_cnt", 32'(slip_cnt), 32'd0);
    check("reset_rx_data",  32'(rx_data),  32'd0);
    cycles(1);
    rst_n = 1;
    cycles(3);

    // Lock with a matching clock lane: aligned after 2 sync + 16 lock + 16 match + 1.
    pll_lock = 1;
    wait_aligned(200, n);
    check("t1_align_latency", 32'(n), 32'd35);
    check("t1_no_slips", 32'(slip_times.size()), 32'd0);

    // Lock loss while aligned, then relock.
    cycles(5);
    pll_lock = 0;
    n = 0;
    while (n < 10) begin
      @(posedge sclk); n++;
      #3;
      if (aligned === 1'b0) break;
    end
    check("t4_drop_within_3", 32'(n <= 3), 32'd1);
    cycles(4);
    pll_lock = 1;
    wait_aligned(200, n);
    check("t4_relock_latency", 32'(n), 32'd35);

    // Three slips required.
    pll_lock = 0;
    cycles(5);
    rot = 3;
    slip_times.delete();
    pll_lock = 1;
    wait_aligned(400, n);
    check("t2_aligned", 32'(n > 0), 32'd1);
    check("t2_slip_pulses", 32'(slip_times.size()), 32'd3);
    for (int i = 1; i < slip_times.size(); i++)
      check("t2_slip_spacing", 32'(slip_times[i] - slip_times[i-1] >= SW + 1), 32'd1);
    check("t2_slip_cnt", 32'(slip_cnt), 32'd3);

    // In-lock monitor behaviour.
    cycles(3);
    bad_left = 3;
    cycles(8);
    check("t6_three_bad_hold", 32'(aligned), 32'd1);
    bad_left = 4;
    cycles(6);
    #2;
`ifdef LVDS_ALIGN_MONITOR_EN
    check("t6_four_bad_drop", 32'(aligned), 32'd0);
    wait_aligned(200, n);
    check("t6_realigned", 32'(n > 0), 32'd1);
    check("t6_slip_cnt", 32'(slip_cnt), 32'd0);
`else
    check("t6_four_bad_hold", 32'(aligned), 32'd1);
    check("t6_slip_cnt", 32'(slip_cnt), 32'd3);
`endif

    // Clock lane never matches: exhaust slips, flag error, keep slipping.
    pll_lock = 0;
    cycles(5);
    never_match = 1;
    slip_times.delete();
    pll_lock = 1;
    n = 0;
    while (n < 2000 && align_err !== 1'b1) begin
      @(posedge sclk); n++;
      #3;
    end
    check("t3_err_set", 32'(align_err), 32'd1);
    check("t3_slips_before_err", 32'(slip_times.size()), 32'd7);
    check("t3_slip_cnt_cleared", 32'(slip_cnt), 32'd0);
    n = 0;
    while (n < 100 && slip_times.size() < 8) begin
      @(posedge sclk); n++;
      #3;
    end
    check("t3_slipping_resumes", 32'(slip_times.size()), 32'd8);
    check("t3_err_sticky", 32'(align_err), 32'd1);

    // Asynchronous reset in the middle of the settle wait.
    cycles(3);
    rst_n = 0;
    #2;
    check("t5_async_aligned",   32'(aligned),   32'd0);
    check("t5_async_slip",      32'(slip),      32'd0);
    check("t5_async_err",       32'(align_err), 32'd0);
    check("t5_async_slip_cnt",  32'(slip_cnt),  32'd0);
    check("t5_async_rx_data",   32'(rx_data),   32'd0);
    never_match = 0;
    rot = 0;
    cycles(3);
    rst_n = 1;
    wait_aligned(200, n);
    check("t5_realign_latency", 32'(n), 32'd35);
    check("t5_err_clear", 32'(align_err), 32'd0);

    cycles(4);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
